// File: rtl/dvp_frame_capture_if.sv
// Bundles the DVP camera pins, the SDRAM write-FIFO port and the frame status
// flags of dvp_frame_capture.
// master: the capture block (drives FIFO writes and status).
// slave:  the environment (camera pins and FIFO full flag).
interface dvp_frame_capture_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [15:0] fifo_wrdata;
  logic        frame_start;
  logic        frame_done;
  logic        frame_ok;
  logic        overflow;
  logic        line_err;

  modport master (
    input  cam_vsync, cam_href, cam_data, fifo_full,
    output fifo_wrreq, fifo_wrdata, frame_start, frame_done,
    output frame_ok, overflow, line_err
  );

  modport slave (
    output cam_vsync, cam_href, cam_data, fifo_full,
    input  fifo_wrreq, fifo_wrdata, frame_start, frame_done,
    input  frame_ok, overflow, line_err
  );
endinterface

// File: rtl/dvp_frame_capture.sv
// DVP camera capture: registers the 8-bit sensor stream, pairs bytes into
// RGB565 words, writes them to the SDRAM write FIFO and reports per-frame
// status. Frame boundaries follow VSYNC; the first SKIP_FRAMES frames after
// reset are discarded while the sensor settles.
module dvp_frame_capture #(
  parameter int unsigned H_PIXELS    = 640,
  parameter int unsigned V_LINES     = 480,
  parameter int unsigned SKIP_FRAMES = 10
) (
  input  logic                 cam_pclk,
  input  logic                 rst,
  dvp_frame_capture_if.master  bus
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    ST_SKIP,
    ST_WAIT_VS,
    ST_ARM,
    ST_CAPTURE
  } state_e;

  // Input stage: s1 = sampled pins, s2 = previous s1 for edge detection
  logic       vs_s1_q, vs_s2_q;
  logic       hr_s1_q, hr_s2_q;
  logic [7:0] data_s1_q;

  logic vs_rise_c, vs_fall_c, hr_rise_c, hr_fall_c;

  state_e              state_q,    state_d;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic                phase_q,    phase_d;
  logic [7:0]          high_q,     high_d;
  logic [CNT_W-1:0]    pix_cnt_q,  pix_cnt_d;
  logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
  logic                wrreq_q,    wrreq_d;
  logic [15:0]         wrdata_q,   wrdata_d;
  logic                start_q,    start_d;
  logic                done_q,     done_d;
  logic                ok_q,       ok_d;
  logic                ovf_q,      ovf_d;
  logic                lerr_q,     lerr_d;
  logic                line_end_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Register the camera pins and keep a delayed copy of the sync lines
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      hr_s1_q   <= 1'b0;
      hr_s2_q   <= 1'b0;
      data_s1_q <= 8'h00;
    end else begin
      vs_s1_q   <= bus.cam_vsync;
      vs_s2_q   <= vs_s1_q;
      hr_s1_q   <= bus.cam_href;
      hr_s2_q   <= hr_s1_q;
      data_s1_q <= bus.cam_data;
    end
  end

  assign vs_rise_c = vs_s1_q & ~vs_s2_q;
  assign vs_fall_c = ~vs_s1_q & vs_s2_q;
  assign hr_rise_c = hr_s1_q & ~hr_s2_q;
  assign hr_fall_c = ~hr_s1_q & hr_s2_q;

  // State, counters and registered outputs
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      state_q    <= ST_SKIP;
      skip_cnt_q <= '0;
      phase_q    <= 1'b0;
      high_q     <= 8'h00;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      wrreq_q    <= 1'b0;
      wrdata_q   <= 16'h0000;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      ovf_q      <= 1'b0;
      lerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      phase_q    <= phase_d;
      high_q     <= high_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      wrreq_q    <= wrreq_d;
      wrdata_q   <= wrdata_d;
      start_q    <= start_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      ovf_q      <= ovf_d;
      lerr_q     <= lerr_d;
    end
  end

  // Frame sequencing, byte pairing, FIFO writes and status flags
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    phase_d    = phase_q;
    high_d     = high_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    wrreq_d    = 1'b0;
    wrdata_d   = wrdata_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    ok_d       = ok_q;
    ovf_d      = ovf_q;
    lerr_d     = lerr_q;
    line_end_c = 1'b0;

    case (state_q)
      ST_SKIP: begin
        // Counter stops at SKIP_FRAMES, so equality is the exit condition
        if (skip_cnt_q == SKIP_W'(SKIP_FRAMES)) begin
          state_d = ST_WAIT_VS;
        end else if (vs_rise_c) begin
          skip_cnt_d = skip_cnt_q + SKIP_W'(1);
        end
      end

      ST_WAIT_VS: begin
        if (vs_rise_c) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        if (vs_fall_c) begin
          start_d    = 1'b1;
          ovf_d      = 1'b0;
          lerr_d     = 1'b0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          phase_d    = 1'b0;
          state_d    = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        // A fresh HREF always starts on the high byte
        if (hr_s1_q) begin
          if (!phase_q || hr_rise_c) begin
            high_d  = data_s1_q;
            phase_d = 1'b1;
          end else begin
            phase_d   = 1'b0;
            pix_cnt_d = sat_inc(pix_cnt_q);
            if (bus.fifo_full) begin
              ovf_d = 1'b1;
            end else begin
              wrreq_d  = 1'b1;
              wrdata_d = {high_q, data_s1_q};
            end
          end
        end

        // VSYNC rising with HREF still high also terminates the line
        line_end_c = hr_fall_c | (vs_rise_c & hr_s1_q);
        if (line_end_c) begin
          phase_d = 1'b0;
          if (pix_cnt_d != CNT_W'(H_PIXELS)) begin
            lerr_d = 1'b1;
          end
          pix_cnt_d  = '0;
          line_cnt_d = sat_inc(line_cnt_q);
        end

        // Status reflects everything up to and including this cycle
        if (vs_rise_c) begin
          done_d  = 1'b1;
          ok_d    = ~ovf_d & ~lerr_d & (line_cnt_d == CNT_W'(V_LINES));
          state_d = ST_ARM;
        end
      end

      default: begin
        state_d = ST_SKIP;
      end
    endcase
  end

  assign bus.fifo_wrreq  = wrreq_q;
  assign bus.fifo_wrdata = wrdata_q;
  assign bus.frame_start = start_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_ok    = ok_q;
  assign bus.overflow    = ovf_q;
  assign bus.line_err    = lerr_q;

endmodule
